// File: rtl/branch_resolver.sv
// Branch resolver: evaluates branch conditions at issue and queues the
// {pc, taken} results in an in-order FIFO, broadcasting the head on the CDB.
module branch_resolver #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [2:0]         issue_op,
    input  logic [31:0]        issue_rs1,
    input  logic [31:0]        issue_rs2,
    input  logic [31:0]        issue_pc,
    output logic               cdb_req,
    input  logic               cdb_gnt,
    output logic [31:0]        cdb_addr,
    output logic [31:0]        cdb_val,
    input  logic               flush,
    output logic [DEPTH_W:0]   occupancy
);

    localparam logic [DEPTH_W:0]   OCC_FULL = (DEPTH_W+1)'(DEPTH);
    localparam logic [DEPTH_W:0]   OCC_ONE  = (DEPTH_W+1)'(1);
    localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

    logic [31:0]        pc_mem [DEPTH];
    logic               tk_mem [DEPTH];
    logic [DEPTH_W-1:0] head;
    logic [DEPTH_W-1:0] tail;
    logic [DEPTH_W:0]   count;
    logic               taken;
    logic               push;
    logic               pop;

    // Branch condition evaluation; reserved funct3 codes never take.
    always_comb begin
        taken = 1'b0;
        case (issue_op)
            3'b000:  taken = (issue_rs1 == issue_rs2);
            3'b001:  taken = (issue_rs1 != issue_rs2);
            3'b100:  taken = ($signed(issue_rs1) <  $signed(issue_rs2));
            3'b101:  taken = ($signed(issue_rs1) >= $signed(issue_rs2));
            3'b110:  taken = (issue_rs1 <  issue_rs2);
            3'b111:  taken = (issue_rs1 >= issue_rs2);
            default: taken = 1'b0;
        endcase
    end

    // Handshake decode; a grant only counts against a visible head, and a
    // flush suppresses both directions.
    always_comb begin
        issue_ready = (count != OCC_FULL);
        cdb_req     = (count != '0);
        push        = rdy_in && issue_valid && issue_ready && !flush;
        pop         = rdy_in && cdb_req && cdb_gnt && !flush;
        cdb_addr    = cdb_req ? pc_mem[head] : 32'b0;
        cdb_val     = {31'b0, cdb_req & tk_mem[head]};
        occupancy   = count;
    end

    // FIFO storage, pointers and count; flush has priority over push/pop.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i] <= 32'b0;
                tk_mem[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    pc_mem[tail] <= issue_pc;
                    tk_mem[tail] <= taken;
                    tail         <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                case ({push, pop})
                    2'b10:   count <= count + OCC_ONE;
                    2'b01:   count <= count - OCC_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: vector table for branch conditions, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_branch_resolver;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [31:0] issue_pc;
    logic        cdb_req;
    logic        cdb_gnt;
    logic [31:0] cdb_addr;
    logic [31:0] cdb_val;
    logic        flush;
    logic [2:0]  occupancy;

    branch_resolver #(.DEPTH(DEPTH), .DEPTH_W(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_pc(issue_pc), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
        .cdb_addr(cdb_addr), .cdb_val(cdb_val), .flush(flush),
        .occupancy(occupancy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [31:0] pc; logic tk; } ent_t;
    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic exp; } vec_t;

    ent_t        q[$];
    logic [31:0] got[$];
    int          errors = 0;
    int          checks = 0;

    function automatic logic ref_taken(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int signed sa = a;
        int signed sb = b;
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("issue_ready", 32'(issue_ready), 32'(q.size() != DEPTH));
        chk("cdb_req", 32'(cdb_req), 32'(q.size() != 0));
        chk("cdb_addr", cdb_addr, (q.size() != 0) ? q[0].pc : 32'h0);
        chk("cdb_val", cdb_val, (q.size() != 0) ? 32'(q[0].tk) : 32'h0);
    endtask

    task automatic drive(logic rdy, logic v, logic [2:0] op, logic [31:0] a,
                         logic [31:0] b, logic [31:0] pc, logic g, logic f);
        rdy_in = rdy; issue_valid = v; issue_op = op; issue_rs1 = a;
        issue_rs2 = b; issue_pc = pc; cdb_gnt = g; flush = f;
    endtask

    // One clock: the model advances with the inputs held across the edge.
    task automatic step();
        bit full, do_push, do_pop;
        full    = (q.size() == DEPTH);
        do_push = rdy_in && issue_valid && !full && !flush;
        do_pop  = rdy_in && cdb_gnt && (q.size() != 0) && !flush;
        if (do_pop) got.push_back(q[0].pc);
        @(posedge clk_in);
        if (rdy_in && flush) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{issue_pc, ref_taken(issue_op, issue_rs1, issue_rs2)});
        end
        #1;
        chk_model();
    endtask

    task automatic idle();
        drive(1, 0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_flush();
        drive(1, 0, 3'd0, 0, 0, 0, 0, 1);
        step();
        idle();
    endtask

    vec_t vecs[] = '{
        '{3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1},
        '{3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0},
        '{3'b000, 32'h5, 32'h5, 1'b1},
        '{3'b000, 32'h5, 32'h6, 1'b0},
        '{3'b001, 32'h5, 32'h6, 1'b1},
        '{3'b001, 32'h9, 32'h9, 1'b0},
        '{3'b101, 32'h1, 32'hFFFF_FFFF, 1'b1},
        '{3'b111, 32'h1, 32'hFFFF_FFFF, 1'b0},
        '{3'b101, 32'h7, 32'h7, 1'b1},
        '{3'b100, 32'h7, 32'h7, 1'b0},
        '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1},
        '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1},
        '{3'b010, 32'h1, 32'h2, 1'b0},
        '{3'b011, 32'h3, 32'h3, 1'b0}
    };

    initial begin
        rst_in = 1'b0;
        drive(0, 0, 3'd0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_issue_ready", 32'(issue_ready), 1);
        chk("rst_cdb_req", 32'(cdb_req), 0);
        chk("rst_cdb_addr", cdb_addr, 0);
        chk("rst_cdb_val", cdb_val, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle();
        step();

        // Condition table: push into empty, check head, then grant it away.
        foreach (vecs[i]) begin
            drive(1, 1, vecs[i].op, vecs[i].a, vecs[i].b, 32'h100 + 32'(i) * 4, 0, 0);
            step();
            chk($sformatf("vec%0d_val", i), cdb_val, 32'(vecs[i].exp));
            chk($sformatf("vec%0d_addr", i), cdb_addr, 32'h100 + 32'(i) * 4);
            chk($sformatf("vec%0d_req", i), 32'(cdb_req), 1);
            drive(1, 0, 3'd0, 0, 0, 0, 1, 0);
            step();
        end

        // Push into empty with grant high must not pop.
        drive(1, 1, 3'd0, 0, 0, 32'h200, 1, 0);
        step();
        chk("push_empty_gnt_occ", 32'(occupancy), 1);
        do_flush();

        // Fill to DEPTH, fifth issue refused, one grant frees a slot.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3'd1, 32'(i), 0, 32'h300 + 32'(i), 0, 0);
            step();
        end
        chk("full_occ", 32'(occupancy), 4);
        chk("full_ready", 32'(issue_ready), 0);
        drive(1, 0, 3'd0, 0, 0, 0, 1, 0);
        step();
        chk("after_gnt_occ", 32'(occupancy), 3);
        chk("after_gnt_ready", 32'(issue_ready), 1);
        do_flush();

        // Wrap-around ordering.
        got.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 3'd0, 0, 0, 32'h10 + 32'(i) * 4, (i >= 3), 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 3'd0, 0, 0, 0, 1, 0);
            step();
        end
        chk("wrap_count", 32'(got.size()), 6);
        for (int i = 0; i < got.size() && i < 6; i++)
            chk($sformatf("wrap_order%0d", i), got[i], 32'h10 + 32'(i) * 4);

        // Flush beats concurrent push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 3'd0, 0, 0, 32'h400 + 32'(i) * 4, 0, 0);
            step();
        end
        drive(1, 1, 3'd0, 0, 0, 32'h500, 1, 1);
        step();
        chk("flush_occ", 32'(occupancy), 0);
        chk("flush_req", 32'(cdb_req), 0);
        chk("flush_addr", cdb_addr, 0);
        idle();

        // rdy_in low freezes everything.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h600 + 32'(i) * 4, 0, 0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3'd0, 0, 0, 32'h700, 1, 0);
            step();
            chk("stall_occ", 32'(occupancy), 2);
            chk("stall_addr", cdb_addr, 32'h600);
            chk("stall_val", cdb_val, 1);
        end
        idle();
        step();

        // Async reset mid-cycle with 2 entries.
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_req", 32'(cdb_req), 0);
        chk("arst_addr", cdb_addr, 0);
        chk("arst_val", cdb_val, 0);
        chk("arst_occ", 32'(occupancy), 0);
        chk("arst_ready", 32'(issue_ready), 1);
        q.delete();
        #1;
        rst_in = 1'b1;
        drive(1, 1, 3'd0, 0, 0, 32'h800, 0, 0);
        step();
        chk("arst_resume_addr", cdb_addr, 32'h800);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                  3'($urandom_range(0, 7)), a, b, $urandom | 32'h1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
